// File: rtl/ula_issue_ctrl.sv
// ula_issue_ctrl
//
// Issue controller that sits between fetch and a purely combinational ULA
// and is the only driver of the ULA input ports. It accepts one 32-bit ALU
// instruction per valid/ready handshake and reads operands from an internal
// 8x32 register file. It presents A/B/opcode to the ULA, then writes the
// ULA result back and latches the low four flag bits.
//
// Sequence per instruction: IDLE -> DECODE -> EXEC -> WB -> IDLE.
// An unsupported opcode takes DECODE -> IDLE and pulses illegal_op.
// result_valid is high for the single WB cycle. The register write, result
// and status_flags commit on the clock edge that ends WB, so they become
// visible (also through dbg_data) in the cycle after the pulse.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears every register
//   instr_valid   instruction offered by fetch
//   instr_ready   controller can accept (IDLE and not in reset)
//   instr         [31:27] opcode, [26:24] rd, [23:21] ra, [20:18] rb,
//                 [17] imm_sel, [16] unused, [15:0] imm
//   alu_a/alu_b   ULA operands, registered in DECODE, held afterwards
//   alu_op        ULA opcode, registered in DECODE, held afterwards
//   alu_out       ULA result
//   alu_flag      ULA flags; only [3:0] are used
//   result_valid  one-cycle pulse during writeback
//   result        last written value
//   status_flags  alu_flag[3:0] captured at writeback
//   illegal_op    one-cycle pulse in DECODE for an unsupported opcode
//   dbg_addr      debug read index
//   dbg_data      combinational read of reg[dbg_addr]; r0 reads 0

module ula_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int IMM_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_flag,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [3:0]  status_flags,
  output logic        illegal_op,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  logic [1:0]       state;
  logic [31:0]      regs [NREGS];

  // Latched instruction fields; bit 16 of the word carries nothing.
  logic [4:0]       op_q;
  logic [2:0]       rd_q;
  logic [2:0]       ra_q;
  logic [2:0]       rb_q;
  logic             sel_q;
  logic [IMM_W-1:0] imm_q;

  // Ignored input bits, reduced so they are visibly consumed.
  wire logic unused_bits = ^{instr[16], alu_flag[31:4]};

  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      5'b00000, 5'b00001, 5'b00011, 5'b00100,
      5'b00101, 5'b00110, 5'b01000, 5'b01001: ok = 1'b1;
      default:                                ok = op[4];
    endcase
    return ok;
  endfunction

  // r0 is hard-wired to zero on every read path.
  function automatic logic [31:0] read_reg(input logic [2:0] idx);
    return (idx == 3'd0) ? 32'd0 : regs[idx];
  endfunction

  logic legal_q;
  assign legal_q = op_legal(op_q);

  // Handshake and pulses are gated by reset so nothing is offered or
  // reported during a reset cycle, whatever state the FSM is in.
  assign instr_ready  = (state == S_IDLE)   && !reset;
  assign result_valid = (state == S_WB)     && !reset;
  assign illegal_op   = (state == S_DECODE) && !legal_q && !reset;
  assign dbg_data     = read_reg(dbg_addr);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; a blocking write here would let later
  // statements in the same edge see the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      sel_q        <= 1'b0;
      imm_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      result       <= '0;
      status_flags <= '0;
      // NOTE: the register file is cleared by reset because software relies
      // on all registers reading zero afterwards; memories that carry no
      // such guarantee are normally left out of reset.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // instr_ready is implied here: IDLE and not in reset.
          if (instr_valid) begin
            op_q  <= instr[31:27];
            rd_q  <= instr[26:24];
            ra_q  <= instr[23:21];
            rb_q  <= instr[20:18];
            sel_q <= instr[17];
            imm_q <= instr[IMM_W-1:0];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (legal_q) begin
            alu_a  <= read_reg(ra_q);
            alu_b  <= sel_q ? {{(32-IMM_W){1'b0}}, imm_q} : read_reg(rb_q);
            alu_op <= op_q;
            state  <= S_EXEC;
          end else begin
            // ULA inputs keep their previous values on the illegal path.
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          state <= S_WB;
        end
        S_WB: begin
          if (rd_q != 3'd0) regs[rd_q] <= alu_out;
          result       <= alu_out;
          status_flags <= alu_flag[3:0];
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Testbench for ula_issue_ctrl. A small combinational ULA stands in for the
// real one; a register-array reference model predicts operands, results,
// flags and register contents from the instruction word fields.
module tb_ula_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out, alu_flag;
  logic        result_valid;
  logic [31:0] result;
  logic [3:0]  status_flags;
  logic        illegal_op;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_regs [8];
  logic [31:0] exp_result;
  logic [3:0]  exp_flags;
  logic [27:0] junk;

  ula_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flag(alu_flag), .result_valid(result_valid),
    .result(result), .status_flags(status_flags), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in ULA behaviour.
  function automatic logic [31:0] ula(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a & b;
      5'd3:    return a + 32'd1;
      5'd4:    return a | b;
      5'd5:    return a - b;
      5'd6:    return a - 32'd1;
      5'd8:    return a ^ b;
      5'd9:    return ~a;
      5'd31:   return 32'd1;
      default: return (a << 1) ^ b ^ {27'd0, op};
    endcase
  endfunction

  function automatic logic [3:0] ula_flags(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    return {^r, (a < b), r[31], (r == 32'd0)};
  endfunction

  // Upper flag bits carry changing garbage the controller must ignore.
  always @(negedge clk) junk <= 28'($urandom);

  always_comb begin
    alu_out  = ula(alu_op, alu_a, alu_b);
    alu_flag = {junk, ula_flags(alu_a, alu_b, alu_out)};
  end

  function automatic logic is_legal(input logic [4:0] op);
    return !(op == 5'd2 || op == 5'd7 || (op >= 5'd10 && op <= 5'd15));
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic sel, input logic [15:0] imm);
    return {op, rd, ra, rb, sel, 1'b0, imm};
  endfunction

  function automatic logic [31:0] mreg(input logic [2:0] idx);
    return (idx == 3'd0) ? 32'd0 : model_regs[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_regs[i] = 32'd0;
    exp_result = 32'd0;
    exp_flags  = 4'd0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      n_checks++;
      if (dbg_data !== mreg(3'(i))) begin
        n_fail++;
        $display("FAIL %s dbg r%0d: got %h expected %h", tag, i, dbg_data, mreg(3'(i)));
      end
    end
  endtask

  // Issue one instruction and follow it cycle by cycle to completion.
  task automatic issue(input logic [31:0] w);
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [31:0] a, b, r;
    logic [3:0]  f;
    int          waited;
    op = w[31:27];
    rd = w[26:24];
    @(negedge clk);
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!instr_ready) begin
      n_fail++;
      $display("FAIL issue_ready_timeout: instr_ready got %b expected 1", instr_ready);
      return;
    end
    instr_valid = 1'b1;
    instr       = w | {15'd0, 1'($urandom), 16'd0};
    a = mreg(w[23:21]);
    b = w[17] ? {16'd0, w[15:0]} : mreg(w[20:18]);

    @(negedge clk);  // cycle k+1: DECODE
    instr_valid = 1'($urandom);
    instr       = $urandom;
    n_checks++;
    if (instr_ready !== 1'b0 || illegal_op !== !is_legal(op) || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_cycle op=%b: ready/illegal/valid got %b%b%b expected 0%b0",
               op, instr_ready, illegal_op, result_valid, !is_legal(op));
    end

    if (!is_legal(op)) begin
      @(negedge clk);  // cycle k+2: back in IDLE
      instr_valid = 1'b0;
      n_checks++;
      if (illegal_op !== 1'b0 || instr_ready !== 1'b1 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_recover op=%b: illegal/ready/valid got %b%b%b expected 010",
                 op, illegal_op, instr_ready, result_valid);
      end
      n_checks++;
      if (result !== exp_result || status_flags !== exp_flags) begin
        n_fail++;
        $display("FAIL illegal_no_update: result %h flags %h expected %h %h",
                 result, status_flags, exp_result, exp_flags);
      end
      check_regs("illegal");
      return;
    end

    @(negedge clk);  // cycle k+2: EXEC
    instr_valid = 1'($urandom);
    instr       = $urandom;
    n_checks++;
    if (alu_a !== a || alu_b !== b || alu_op !== op) begin
      n_fail++;
      $display("FAIL alu_inputs: a %h b %h op %b expected %h %h %b", alu_a, alu_b, alu_op, a, b, op);
    end
    n_checks++;
    if (result_valid !== 1'b0 || instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_cycle: valid/ready got %b%b expected 00", result_valid, instr_ready);
    end

    @(negedge clk);  // cycle k+3: WB
    instr_valid = 1'b0;
    n_checks++;
    if (result_valid !== 1'b1 || alu_a !== a || alu_b !== b || alu_op !== op) begin
      n_fail++;
      $display("FAIL wb_cycle: valid %b a %h b %h op %b expected 1 %h %h %b",
               result_valid, alu_a, alu_b, alu_op, a, b, op);
    end

    r = ula(op, a, b);
    f = ula_flags(a, b, r);
    @(negedge clk);  // cycle k+4: writeback visible
    if (rd != 3'd0) model_regs[rd] = r;
    exp_result = r;
    exp_flags  = f;
    n_checks++;
    if (result_valid !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_wb: valid/ready got %b%b expected 01", result_valid, instr_ready);
    end
    n_checks++;
    if (result !== exp_result || status_flags !== exp_flags) begin
      n_fail++;
      $display("FAIL writeback op=%b: result %h flags %h expected %h %h",
               op, result, status_flags, exp_result, exp_flags);
    end
    n_checks++;
    if (alu_a !== a || alu_b !== b || alu_op !== op) begin
      n_fail++;
      $display("FAIL alu_hold_idle: a %h b %h op %b expected %h %h %b", alu_a, alu_b, alu_op, a, b, op);
    end
    dbg_addr = rd;
    #1;
    n_checks++;
    if (dbg_data !== mreg(rd)) begin
      n_fail++;
      $display("FAIL dbg_rd r%0d: got %h expected %h", rd, dbg_data, mreg(rd));
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = mk(5'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd3);
    dbg_addr    = 3'd0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (instr_ready !== 1'b0 || result_valid !== 1'b0 || illegal_op !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_handshake: ready/valid/illegal got %b%b%b expected 000",
                 instr_ready, result_valid, illegal_op);
      end
    end
    n_checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 5'd0 || result !== 32'd0 || status_flags !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: a %h b %h op %b result %h flags %h expected all zero",
               alu_a, alu_b, alu_op, result, status_flags);
    end
    reset       = 1'b0;
    instr_valid = 1'b0;
    model_clear();
    check_regs("reset");
  endtask

  task automatic test_basic();
    issue(mk(5'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5));
    issue(mk(5'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7));
    issue(mk(5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0));
    dbg_addr = 3'd3;
    #1;
    n_checks++;
    if (dbg_data !== 32'd12 || result !== 32'd12) begin
      n_fail++;
      $display("FAIL basic_add: dbg %h result %h expected 0000000c", dbg_data, result);
    end
  endtask

  task automatic test_wrap();
    issue(mk(5'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF));
    issue(mk(5'd6, 3'd4, 3'd0, 3'd0, 1'b1, 16'd0));
    dbg_addr = 3'd4;
    #1;
    n_checks++;
    if (dbg_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_dec: dbg r4 %h expected ffffffff", dbg_data);
    end
    issue(mk(5'd3, 3'd4, 3'd4, 3'd0, 1'b1, 16'd0));
    dbg_addr = 3'd4;
    #1;
    n_checks++;
    if (dbg_data !== 32'd0 || status_flags[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_inc: dbg r4 %h zero flag %b expected 0 1", dbg_data, status_flags[0]);
    end
  endtask

  task automatic test_illegal();
    logic [4:0] ops [5];
    ops = '{5'b01100, 5'b00010, 5'b00111, 5'b01010, 5'b01111};
    for (int i = 0; i < 5; i++) issue(mk(ops[i], 3'd5, 3'd1, 3'd2, 1'b0, 16'h0F0F));
  endtask

  task automatic test_r0_write();
    issue(mk(5'd31, 3'd0, 3'd3, 3'd1, 1'b0, 16'd0));
    dbg_addr = 3'd0;
    #1;
    n_checks++;
    if (result !== 32'd1 || dbg_data !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_write: result %h dbg r0 %h expected 1 0", result, dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] stream [3];
    logic [31:0] exp_r  [3];
    int accepts, pulses, last_acc;
    logic saw_pulse;
    stream[0] = mk(5'd0, 3'd6, 3'd3, 3'd0, 1'b1, 16'd100);
    stream[1] = mk(5'd5, 3'd7, 3'd6, 3'd3, 1'b0, 16'd0);
    stream[2] = mk(5'd8, 3'd6, 3'd7, 3'd6, 1'b0, 16'd0);
    // Strictly serial issue: results follow from applying the stream in order.
    for (int j = 0; j < 3; j++) begin
      logic [31:0] a, b;
      a = mreg(stream[j][23:21]);
      b = stream[j][17] ? {16'd0, stream[j][15:0]} : mreg(stream[j][20:18]);
      exp_r[j] = ula(stream[j][31:27], a, b);
      if (stream[j][26:24] != 3'd0) model_regs[stream[j][26:24]] = exp_r[j];
      exp_flags = ula_flags(a, b, exp_r[j]);
    end
    exp_result = exp_r[2];
    accepts = 0; pulses = 0; last_acc = -1; saw_pulse = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (accepts == 3 && instr_ready) instr_valid = 1'b0;
      else if (accepts < 3) instr = stream[accepts];
      if (result_valid) begin
        pulses++;
        saw_pulse = 1'b1;
      end else if (saw_pulse) begin
        saw_pulse = 1'b0;
        n_checks++;
        if (pulses > 3 || result !== exp_r[pulses-1]) begin
          n_fail++;
          $display("FAIL b2b_result #%0d: got %h expected %h", pulses, result, exp_r[(pulses-1)%3]);
        end
      end
      if (instr_valid && instr_ready) begin
        if (accepts > 0) begin
          n_checks++;
          if (cyc - last_acc != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected 4", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepts++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    n_checks++;
    if (accepts != 3 || pulses != 3) begin
      n_fail++;
      $display("FAIL b2b_count: accepts %0d pulses %0d expected 3 3", accepts, pulses);
    end
    check_regs("b2b");
  endtask

  task automatic test_reset_midflight();
    issue(mk(5'd0, 3'd3, 3'd0, 3'd0, 1'b1, 16'h1234));
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(5'd0, 3'd5, 3'd3, 3'd0, 1'b1, 16'd9);
    @(negedge clk);  // DECODE
    instr_valid = 1'b0;
    @(negedge clk);  // EXEC
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = mk(5'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd1);
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || instr_ready !== 1'b0 || illegal_op !== 1'b0) begin
        n_fail++;
        $display("FAIL midflight_reset: valid/ready/illegal got %b%b%b expected 000",
                 result_valid, instr_ready, illegal_op);
      end
    end
    n_checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 5'd0 || result !== 32'd0 || status_flags !== 4'd0) begin
      n_fail++;
      $display("FAIL midflight_outputs: a %h b %h op %b result %h flags %h expected all zero",
               alu_a, alu_b, alu_op, result, status_flags);
    end
    reset       = 1'b0;
    instr_valid = 1'b0;
    model_clear();
    check_regs("midflight");
    issue(mk(5'd0, 3'd5, 3'd0, 3'd0, 1'b1, 16'd77));
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      issue({5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b0, 16'($urandom)});
    end
    check_regs("random");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_illegal();
    test_r0_write();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
